// File: rtl/npu_csa_pkg.sv
// Shared types and default widths for the carry-save packet accumulator.
package npu_csa_pkg;

  localparam int W_DEF     = 8;
  localparam int ACC_W_DEF = 20;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2
  } csa_state_e;

endpackage

// File: rtl/csa_row.sv
// One row of full adders: compresses three N-bit vectors into a sum vector and a
// carry vector. carry[i] has weight 2^(i+1); the caller does the shift.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic carry
);
  assign s     = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);
endmodule

module csa_row #(
  parameter int N = 20
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  output logic [N-1:0] s,
  output logic [N-1:0] carry
);
  for (genvar i = 0; i < N; i++) begin : g_fa
    full_adder u_fa (
      .a     (a[i]),
      .b     (b[i]),
      .c     (c[i]),
      .s     (s[i]),
      .carry (carry[i])
    );
  end
endmodule

// File: rtl/csa_accum.sv
// Packet accumulator: sums signed beats in carry-save form, resolves the redundant
// pair with one carry-propagate add, then presents the sum and a saturating beat count.
//
// state   | meaning
// ACCUM   | accepting beats into S/C, in_ready=1
// RESOLVE | one cycle: out_data <= S + (C<<1)
// OUTPUT  | out_valid=1, hold result until out_ready; handshake clears S/C/count
module csa_accum
  import npu_csa_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count
);

  csa_state_e       state_q, state_d;
  logic [ACC_W-1:0] s_q, c_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ACC_W-1:0] c_shift, din_ext, row_s, row_c;
  logic             accept, handshake;

  assign accept    = in_valid & in_ready;
  assign handshake = out_valid & out_ready;
  assign c_shift   = {c_q[ACC_W-2:0], 1'b0};
  assign din_ext   = {{(ACC_W-W){in_data[W-1]}}, in_data};

  csa_row #(.N(ACC_W)) u_row (
    .a     (s_q),
    .b     (c_shift),
    .c     (din_ext),
    .s     (row_s),
    .carry (row_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept && in_last) state_d = RESOLVE;
      RESOLVE: state_d = OUTPUT;
      OUTPUT:  if (out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == OUTPUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q       <= '0;
      c_q       <= '0;
      cnt_q     <= '0;
      out_data  <= '0;
      out_count <= '0;
    end else begin
      if (accept) begin
        s_q <= row_s;
        c_q <= row_c;
        if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
      end
      // The only carry-propagate add in the block; S/C stay valid until the handshake.
      if (state_q == RESOLVE) begin
        out_data  <= s_q + c_shift;
        out_count <= cnt_q;
      end
      if (handshake) begin
        s_q   <= '0;
        c_q   <= '0;
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_csa_accum.sv
// Self-checking bench for csa_accum: directed scenarios plus random packets checked
// against an arithmetic model of the packet sum and saturating beat count.
module tb_csa_accum;
  localparam int W = 8, ACC_W = 20, CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [W-1:0]     in_data = '0;
  logic             in_ready, out_valid;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] pkt[$];

  csa_accum #(.W(W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  function automatic logic [ACC_W-1:0] model_sum();
    int s = 0;
    foreach (pkt[i]) s += int'($signed(pkt[i]));
    return ACC_W'(s);
  endfunction

  function automatic logic [CNT_W-1:0] model_count();
    int n = pkt.size();
    return (n > 255) ? CNT_W'(255) : CNT_W'(n);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Sends pkt with random idle gaps; last beat carries in_last when with_last is set.
  task automatic send_beats(input string tag, input int max_gap, input bit with_last);
    bit acc;
    for (int i = 0; i < pkt.size(); i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_last  = 1'($urandom);
        cyc();
      end
      in_valid = 1'b1;
      in_data  = pkt[i];
      in_last  = with_last && (i == pkt.size() - 1);
      acc = 1'b0;
      for (int k = 0; k < 50 && !acc; k++) begin
        acc = in_ready;
        cyc();
      end
      if (!acc) begin
        total++; bad++;
        $display("FAIL %s accept_timeout beat=%0d in_ready=%b required=1", tag, i, in_ready);
        in_valid = 1'b0; in_last = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called #1 after the last accept edge; checks RESOLVE, OUTPUT hold and handshake.
  task automatic collect(input string tag, input int hold);
    logic [ACC_W-1:0] exp_d;
    logic [CNT_W-1:0] exp_c;
    exp_d = model_sum();
    exp_c = model_count();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s resolve_cycle out_valid=%b in_ready=%b required 0/0", tag, out_valid, in_ready);
    end
    cyc();
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s out_valid_latency got=%b required=1", tag, out_valid);
    end
    total++;
    if (out_data !== exp_d) begin
      bad++;
      $display("FAIL %s out_data got=%h required=%h", tag, out_data, exp_d);
    end
    total++;
    if (out_count !== exp_c) begin
      bad++;
      $display("FAIL %s out_count got=%0d required=%0d", tag, out_count, exp_c);
    end
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = W'($urandom);
      in_last  = 1'b1;
      cyc();
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp_d || out_count !== exp_c) begin
        bad++;
        $display("FAIL %s hold cyc=%0d valid=%b ready=%b data=%h cnt=%0d required 1/0/%h/%0d",
                 tag, h, out_valid, in_ready, out_data, out_count, exp_d, exp_c);
      end
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s after_handshake out_valid=%b in_ready=%b required 0/1", tag, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_count !== '0) begin
        bad++;
        $display("FAIL reset_hold valid=%b data=%h cnt=%0d required 0/0/0", out_valid, out_data, out_count);
      end
    end
    rst_n = 1'b1;
    cyc();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
      bad++;
      $display("FAIL reset_release in_ready=%b out_valid=%b data=%h required 1/0/0", in_ready, out_valid, out_data);
    end
  endtask

  task automatic test_basic();
    pkt = {8'd1, 8'd2, 8'd3, 8'd4};
    send_beats("basic", 0, 1'b1);
    collect("basic", 0);
  endtask

  task automatic test_signed();
    pkt = {8'hFB, 8'h03};
    send_beats("signed", 1, 1'b1);
    collect("signed", 0);
  endtask

  task automatic test_backpressure();
    pkt = {8'd7};
    send_beats("bp_single", 0, 1'b1);
    collect("bp_single", 5);
    pkt = {8'd2, 8'd3};
    send_beats("bp_next", 0, 1'b1);
    collect("bp_next", 0);
  endtask

  task automatic test_saturation();
    pkt.delete();
    repeat (300) pkt.push_back(8'd1);
    send_beats("saturate", 0, 1'b1);
    collect("saturate", 1);
  endtask

  task automatic test_reset_mid();
    pkt = {8'd9, 8'd9};
    send_beats("mid_pkt", 0, 1'b0);
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      bad++;
      $display("FAIL mid_reset_assert out_valid=%b data=%h required 0/0", out_valid, out_data);
    end
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL mid_reset_idle out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      end
    end
    pkt = {8'd7};
    send_beats("after_mid", 0, 1'b1);
    collect("after_mid", 0);

    // Reset while a result is pending in OUTPUT.
    pkt = {8'd5, 8'd6};
    send_beats("out_reset", 0, 1'b1);
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_count !== '0) begin
      bad++;
      $display("FAIL output_reset valid=%b data=%h cnt=%0d required 0/0/0", out_valid, out_data, out_count);
    end
    cyc();
    rst_n = 1'b1;
    cyc();
    pkt = {8'hFF};
    send_beats("after_out_reset", 0, 1'b1);
    collect("after_out_reset", 0);
  endtask

  task automatic test_random();
    for (int p = 0; p < 25; p++) begin
      pkt.delete();
      repeat ($urandom_range(1, 12)) pkt.push_back(W'($urandom));
      send_beats("random", 2, 1'b1);
      collect("random", $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
